// File: rtl/issue_pkg.sv
// Shared types for the issue select stage: the micro-op record and register-type codes.
package issue_pkg;

  localparam int ISSUE_PREG_W = 7;

  localparam logic [1:0] RT_FIX = 2'b00;
  localparam logic [1:0] RT_FLT = 2'b01;
  localparam logic [1:0] RT_X   = 2'b10;

  typedef struct packed {
    logic [6:0]              uopc;
    logic [31:0]             inst;
    logic [11:0]             br_mask;
    logic [ISSUE_PREG_W-1:0] pdst;
    logic [ISSUE_PREG_W-1:0] prs1;
    logic [ISSUE_PREG_W-1:0] prs2;
    logic                    ldst_val;
    logic [1:0]              dst_rtype;
    logic [1:0]              lrs1_rtype;
    logic [1:0]              lrs2_rtype;
    logic                    bypassable;
  } uop_t;

  // A uop produces a wakeup only if it writes a real destination register.
  function automatic logic has_wakeup(input uop_t u);
    return u.ldst_val && (u.dst_rtype != RT_X);
  endfunction

endpackage

// File: rtl/issue_select_age_matrix.sv
// Age matrix for oldest-first selection; age_q[i][j]=1 means slot i is older than slot j.
module age_matrix
  import issue_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SLOTS-1:0] alloc,
  input  logic [NUM_SLOTS-1:0] request,
  output logic [NUM_SLOTS-1:0] oldest
);

  logic [NUM_SLOTS-1:0] age_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] age_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] cand;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = 0; j < NUM_SLOTS; j++) begin
        if (i == j) begin
          age_d[i][j] = 1'b0;
        end else if (alloc[i]) begin
          // Among same-cycle allocations the lower index is the older one.
          age_d[i][j] = alloc[j] && (j > i);
        end else if (alloc[j]) begin
          age_d[i][j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      age_q <= '{default: '0};
    end else begin
      age_q <= age_d;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_col
      logic [NUM_SLOTS-1:0] older;
      for (gj = 0; gj < NUM_SLOTS; gj++) begin : g_bit
        assign older[gj] = age_q[gj][gi];
      end
      assign cand[gi] = request[gi] & ~|(older & request);
    end
  endgenerate

  // Slots with no recorded ordering (e.g. after reset) tie; the lowest index wins.
  always_comb begin
    logic found;
    found  = 1'b0;
    oldest = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (cand[i] && !found) begin
        oldest[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_select.sv
// Issue select: picks one requesting slot per cycle, registers the uop, and broadcasts wakeups.
// Define ISSUE_SELECT_AGE_EN for oldest-first selection; otherwise the lowest index wins.
module issue_select
  import issue_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int PREG_W    = ISSUE_PREG_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SLOTS-1:0]        io_request,
  input  logic [NUM_SLOTS-1:0]        io_alloc,
  input  uop_t [NUM_SLOTS-1:0]        io_slot_uop,
  output logic [NUM_SLOTS-1:0]        io_grant,
  input  logic                        io_kill,
  input  logic                        io_fu_ready,
  output logic                        io_out_valid,
  output uop_t                        io_out_uop,
  output logic                        io_wakeup_valid,
  output logic [PREG_W-1:0]           io_wakeup_pdst
);

  logic [NUM_SLOTS-1:0] sel_oh;
  logic                 can_issue;
  logic                 any_grant;
  uop_t                 sel_uop;

  logic                 out_valid_q, out_valid_d;
  uop_t                 out_uop_q, out_uop_d;
  logic                 wakeup_valid_q, wakeup_valid_d;
  logic [PREG_W-1:0]    wakeup_pdst_q, wakeup_pdst_d;

`ifdef ISSUE_SELECT_AGE_EN
  // A slot being written this cycle cannot request until the next one.
  age_matrix #(.NUM_SLOTS(NUM_SLOTS)) u_age_matrix (
    .clk     (clk),
    .reset   (reset),
    .alloc   (io_alloc),
    .request (io_request & ~io_alloc),
    .oldest  (sel_oh)
  );
`else
  logic [NUM_SLOTS-1:0] unused_alloc;
  assign unused_alloc = io_alloc;

  always_comb begin
    logic found;
    found  = 1'b0;
    sel_oh = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (io_request[i] && !found) begin
        sel_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`endif

  assign can_issue = (!out_valid_q || io_fu_ready) && !io_kill && !reset;
  assign io_grant  = can_issue ? sel_oh : '0;
  assign any_grant = |io_grant;

  always_comb begin
    sel_uop = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (io_grant[i]) sel_uop = io_slot_uop[i];
    end
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_uop_d      = out_uop_q;
    wakeup_valid_d = 1'b0;
    wakeup_pdst_d  = wakeup_pdst_q;
    if (io_kill) begin
      out_valid_d = 1'b0;
    end else if (any_grant) begin
      out_valid_d = 1'b1;
      out_uop_d   = sel_uop;
      if (has_wakeup(sel_uop)) begin
        wakeup_valid_d = 1'b1;
        wakeup_pdst_d  = PREG_W'(sel_uop.pdst);
      end
    end else if (io_fu_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_uop_q      <= '0;
      wakeup_valid_q <= 1'b0;
      wakeup_pdst_q  <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_uop_q      <= out_uop_d;
      wakeup_valid_q <= wakeup_valid_d;
      wakeup_pdst_q  <= wakeup_pdst_d;
    end
  end

  assign io_out_valid    = out_valid_q;
  assign io_out_uop      = out_uop_q;
  assign io_wakeup_valid = wakeup_valid_q;
  assign io_wakeup_pdst  = wakeup_pdst_q;

endmodule

// File: doc/issue_select.md
# issue_select

Oldest-first select stage for the issue unit. Sits directly downstream of the issue slots. Each cycle it picks at most one requesting slot and returns a one-hot grant to that slot. It captures the granted micro-op into an output register that feeds the functional unit over a valid/ready handshake. It also broadcasts the destination tag on the wakeup port that the slots consume.

## Interface
Parameters:
- NUM_SLOTS, 8: number of issue slots arbitrated; 2..16.
- PREG_W, 7: physical register tag width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- io_request, in, NUM_SLOTS: slot i holds a ready, valid uop.
- io_alloc, in, NUM_SLOTS: pulse; slot i written with a new uop this cycle (age tracking).
- io_slot_uop, in, NUM_SLOTS x uop_t: current uop of each slot.
- io_grant, out, NUM_SLOTS: one-hot (or zero) grant; combinational, same cycle as request.
- io_kill, in, 1: pipeline flush.
- io_fu_ready, in, 1: functional unit accepts io_out_uop this cycle.
- io_out_valid, out, 1: output register holds an issued uop.
- io_out_uop, out, uop_t: issued uop.
- io_wakeup_valid, out, 1: one-cycle pulse; tag broadcast.
- io_wakeup_pdst, out, PREG_W: woken destination tag.

## Operation
- can_issue = !io_out_valid | io_fu_ready, gated by !io_kill.
- Grant:
  - When can_issue, io_grant selects the oldest slot with io_request=1.
  - Otherwise io_grant = 0.
  - io_grant is never asserted for a slot without io_request.
- Capture on a grant: the output register loads io_slot_uop[sel] and io_out_valid=1 at the next edge.
- Handshake:
  - io_out_valid stays high with io_out_uop stable until io_fu_ready=1.
  - Accept with no new grant: io_out_valid=0 next cycle.
  - Accept plus new grant in the same cycle: the register reloads back-to-back with no bubble.
- Wakeup:
  - The cycle after a grant of a uop with ldst_val=1 and dst_rtype != RT_X, io_wakeup_valid=1 and io_wakeup_pdst=uop.pdst.
  - Pulses exactly once per issued uop, independent of io_fu_ready stalls.
  - Otherwise io_wakeup_valid=0 and io_wakeup_pdst holds its last value.
- Age matrix, NUM_SLOTS x NUM_SLOTS bits; age[i][j]=1 means slot i is older than j.
  - On io_alloc[i]: row i cleared and column i set, so i is youngest.
  - Simultaneous allocs: a lower index is older than a higher index.
  - Diagonal is always 0.
  - Oldest requester: request i set and no requesting j with age[j][i]=1.
- io_kill:
  - Grant suppressed that cycle.
  - Next edge: io_out_valid=0 and io_wakeup_valid=0.
  - The age matrix is unaffected.
- Reset: io_out_valid=0, io_wakeup_valid=0, io_wakeup_pdst=0, io_out_uop=0, age matrix all 0. io_grant=0 while reset is high.

## Timing
- Request to grant: 0 cycles (combinational).
- Grant to io_out_valid and io_wakeup_valid: 1 cycle.
- Sustained throughput: 1 uop/cycle with io_fu_ready held high.
- Stall: io_fu_ready=0 with io_out_valid=1 gives io_grant=0 every cycle until accepted.
- Kill and grant in the same cycle: kill wins; no capture.
- Reset asserted mid-stall discards the held uop.
- Alloc and request on the same slot in the same cycle: the request is ignored until the next cycle (slots cannot request on the write cycle).

## Configuration
- ISSUE_SELECT_AGE_EN defined: age-matrix oldest-first selection, as above.
- ISSUE_SELECT_AGE_EN undefined:
  - Fixed priority; the lowest-index requester wins.
  - No age matrix storage; io_alloc is ignored.
- All other behaviour is identical in both builds.

## Structure
- issue_pkg holds:
  - uop_t, packed: uopc[6:0], inst[31:0], br_mask[11:0], pdst, prs1, prs2[PREG_W-1:0], ldst_val, dst_rtype[1:0], lrs1_rtype, lrs2_rtype, bypassable.
  - Rtype constants: RT_FIX=2'b00, RT_FLT=2'b01, RT_X=2'b10.
- One sub-module, age_matrix: takes alloc and request vectors, produces a one-hot oldest vector. Instantiated only under ISSUE_SELECT_AGE_EN.

## Test plan
- Reset, then requests 8'hFF, fu_ready=1, no prior alloc (all ages 0) → io_grant=8'h01 with age on; io_out_valid=1 next cycle.
- Alloc slot 5, then 2, then 6; request 8'h64 → grant 8'h20. Drop bit 5 → grant 8'h04. Without the macro: 8'h04, then 8'h04.
- Grant slot 3 (pdst=7'd42, ldst_val=1, dst_rtype=RT_FIX), fu_ready=0 for 3 cycles:
  - Wakeup pulses once, pdst=42.
  - io_out_uop stable; io_grant=0 throughout.
  - Issues when fu_ready=1.
- Continuous requests on slots 0..3, fu_ready=1 → four uops on four consecutive cycles, no bubbles.
- io_kill asserted with io_out_valid=1 and request pending → io_grant=0; io_out_valid=0 and io_wakeup_valid=0 next cycle.
- Grant of a store (ldst_val=0) → io_out_valid=1, io_wakeup_valid stays 0.
